// File: rtl/qspi_flash_responder.sv
// Single-lane SPI (mode 0) flash target backed by an internal byte RAM.
// The pins are oversampled in the clk domain. Supported commands are
// RDID, RDSR, RFSR, WREN, READ, PP, SE and BE, with emulated busy time.
// Ports:
//   clk, reset      system clock (>= 4x sck), synchronous active-high reset
//   sck, S, dq0_i   SPI clock, active-low chip select, MOSI (all async)
//   dq1_o, dq1_oe   MISO data and its output enable
//   wip, wel        write-in-progress and write-enable-latch status bits
module qspi_flash_responder #(
  parameter int unsigned DEPTH        = 4096,
  parameter int unsigned SECTOR_BYTES = 1024,
  parameter logic [23:0] JEDEC_ID     = 24'h20BA18,
  parameter int unsigned BUSY_CYCLES  = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic sck,
  input  logic S,
  input  logic dq0_i,
  output logic dq1_o,
  output logic dq1_oe,
  output logic wip,
  output logic wel
);

  localparam int unsigned   AW        = $clog2(DEPTH);
  localparam int unsigned   CW        = $clog2(BUSY_CYCLES + 1);
  localparam logic [AW-1:0] SECT_MASK = AW'(SECTOR_BYTES - 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  localparam logic [7:0] OP_RDID = 8'h9F;
  localparam logic [7:0] OP_RDSR = 8'h05;
  localparam logic [7:0] OP_RFSR = 8'h70;
  localparam logic [7:0] OP_WREN = 8'h06;
  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_PP   = 8'h02;
  localparam logic [7:0] OP_SE   = 8'hD8;
  localparam logic [7:0] OP_BE   = 8'hC7;

  typedef enum logic [2:0] {
    S_IDLE, S_OPCODE, S_ADDR, S_DATA_IN, S_DATA_OUT, S_IGNORE, S_ERASE, S_PROG_WAIT
  } state_t;

  // Frame FSM uses IDLE..IGNORE; the busy engine uses IDLE/ERASE/PROG_WAIT so
  // status polling frames can run while a program/erase is in progress.
  state_t r_state, w_state_nx, r_bsy, w_bsy_nx;

  logic [1:0]    r_sck_s, r_s_s, r_dq0_s;
  logic          r_sck_d, r_s_d;
  logic          w_sck_rise, w_sck_fall, w_s_rise, w_s_fall;
  logic [7:0]    r_rx, r_opcode, r_tx, w_rx_byte, w_opc, w_load_byte;
  logic [2:0]    r_bit_cnt, r_byte_cnt, r_out_cnt, w_bit_cnt_nx, w_byte_cnt_nx;
  logic          r_cmd_ok, w_ok, w_byte_done;
  logic [1:0]    r_id_idx, w_id_idx;
  logic [AW-1:0] r_addr, w_addr_shift, w_addr_nx, w_rd_addr;
  logic [AW-1:0] r_er_addr, r_er_last;
  logic [CW-1:0] r_busy_cnt;
  logic          w_cmd_end, w_len8, w_set_wel, w_start_be, w_start_se, w_start_pp;
  logic          w_pp_we;
  logic [7:0]    r_ram [DEPTH];

  // Pin synchronizers plus one delay stage for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sck_s <= 2'b00;
      r_s_s   <= 2'b11;
      r_dq0_s <= 2'b00;
      r_sck_d <= 1'b0;
      r_s_d   <= 1'b1;
    end else begin
      r_sck_s <= {r_sck_s[0], sck};
      r_s_s   <= {r_s_s[0], S};
      r_dq0_s <= {r_dq0_s[0], dq0_i};
      r_sck_d <= r_sck_s[1];
      r_s_d   <= r_s_s[1];
    end
  end

  assign w_sck_rise   = r_sck_s[1] & ~r_sck_d;
  assign w_sck_fall   = ~r_sck_s[1] & r_sck_d;
  assign w_s_rise     = r_s_s[1] & ~r_s_d;
  assign w_s_fall     = ~r_s_s[1] & r_s_d;
  assign w_rx_byte    = {r_rx[6:0], r_dq0_s[1]};
  assign w_addr_shift = AW'({r_addr, w_rx_byte});

  // Frame FSM state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nx;
  end

  // Frame next-state: the sck edge is applied first, then a same-cycle S rise
  always_comb begin
    w_state_nx    = r_state;
    w_opc         = r_opcode;
    w_ok          = r_cmd_ok;
    w_byte_done   = 1'b0;
    w_bit_cnt_nx  = r_bit_cnt;
    w_byte_cnt_nx = r_byte_cnt;
    if (w_s_fall) begin
      w_state_nx    = S_OPCODE;
      w_ok          = 1'b0;
      w_bit_cnt_nx  = 3'd0;
      w_byte_cnt_nx = 3'd0;
    end else if (w_sck_rise && r_state != S_IDLE) begin
      w_bit_cnt_nx = r_bit_cnt + 3'd1;
      if (r_bit_cnt == 3'd7) begin
        w_byte_done = 1'b1;
        if (r_byte_cnt != 3'd7) w_byte_cnt_nx = r_byte_cnt + 3'd1;
        case (r_state)
          S_OPCODE: begin
            w_opc      = w_rx_byte;
            w_ok       = 1'b1;
            w_state_nx = S_IGNORE;
            if (wip && w_rx_byte != OP_RDSR && w_rx_byte != OP_RFSR) begin
              w_ok = 1'b0;
            end else begin
              case (w_rx_byte)
                OP_RDID, OP_RDSR, OP_RFSR: w_state_nx = S_DATA_OUT;
                OP_READ:                   w_state_nx = S_ADDR;
                OP_PP, OP_SE: begin
                  w_ok       = wel;
                  w_state_nx = wel ? S_ADDR : S_IGNORE;
                end
                OP_BE:   w_ok = wel;
                OP_WREN: w_ok = 1'b1;  // length is checked at frame end
                default: w_ok = 1'b0;
              endcase
            end
          end
          S_ADDR: begin
            if (r_byte_cnt == 3'd3) begin
              case (r_opcode)
                OP_READ: w_state_nx = S_DATA_OUT;
                OP_PP:   w_state_nx = S_DATA_IN;
                default: w_state_nx = S_IGNORE;  // SE waits for exact frame end
              endcase
            end
          end
          default: w_state_nx = r_state;
        endcase
      end
    end
    if (w_s_rise) w_state_nx = S_IDLE;
  end

  // Frame-end qualification of write/erase commands
  assign w_cmd_end  = w_s_rise && w_ok && (r_state != S_IDLE);
  assign w_len8     = (w_byte_cnt_nx == 3'd1) && (w_bit_cnt_nx == 3'd0);
  assign w_set_wel  = w_cmd_end && (w_opc == OP_WREN) && w_len8;
  assign w_start_be = w_cmd_end && (w_opc == OP_BE) && w_len8;
  assign w_start_se = w_cmd_end && (w_opc == OP_SE) &&
                      (w_byte_cnt_nx == 3'd4) && (w_bit_cnt_nx == 3'd0);
  assign w_start_pp = w_cmd_end && (w_opc == OP_PP) &&
                      (w_byte_cnt_nx >= 3'd5) && (w_bit_cnt_nx == 3'd0);
  assign w_pp_we    = w_byte_done && (r_state == S_DATA_IN);
  assign w_addr_nx  = (w_byte_done && r_state == S_ADDR) ? w_addr_shift : r_addr;

  // Byte to shift out: first byte at dispatch, following bytes on reload
  always_comb begin
    w_id_idx    = (r_state == S_DATA_OUT) ? r_id_idx : 2'd0;
    w_rd_addr   = (r_state == S_DATA_OUT) ? r_addr + AW'(1) : w_addr_shift;
    w_load_byte = 8'h00;
    case (w_opc)
      OP_RDID: begin
        case (w_id_idx)
          2'd0:    w_load_byte = JEDEC_ID[23:16];
          2'd1:    w_load_byte = JEDEC_ID[15:8];
          2'd2:    w_load_byte = JEDEC_ID[7:0];
          default: w_load_byte = 8'h00;
        endcase
      end
      OP_RDSR: w_load_byte = {6'b0, wel, wip};
      OP_RFSR: w_load_byte = {~wip, 7'b0};
      OP_READ: w_load_byte = r_ram[w_rd_addr];
      default: w_load_byte = 8'h00;
    endcase
  end

  // Shift datapath, status bits and erase address counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx       <= 8'h00;
      r_opcode   <= 8'h00;
      r_tx       <= 8'h00;
      r_cmd_ok   <= 1'b0;
      r_bit_cnt  <= 3'd0;
      r_byte_cnt <= 3'd0;
      r_out_cnt  <= 3'd0;
      r_id_idx   <= 2'd0;
      r_addr     <= '0;
      r_er_addr  <= '0;
      r_er_last  <= '0;
      r_busy_cnt <= '0;
      dq1_o      <= 1'b0;
      dq1_oe     <= 1'b0;
      wip        <= 1'b0;
      wel        <= 1'b0;
    end else begin
      r_bit_cnt  <= w_bit_cnt_nx;
      r_byte_cnt <= w_byte_cnt_nx;
      r_opcode   <= w_opc;
      r_cmd_ok   <= w_ok;
      dq1_oe     <= (w_state_nx == S_DATA_OUT);
      wip        <= (w_bsy_nx != S_IDLE);
      if (w_sck_rise && r_state != S_IDLE) r_rx <= w_rx_byte;
      r_addr <= w_addr_nx;
      if (w_pp_we) r_addr[7:0] <= r_addr[7:0] + 8'd1;  // wraps within the page
      if (w_byte_done && w_state_nx == S_DATA_OUT && r_state != S_DATA_OUT) begin
        r_tx      <= w_load_byte;
        r_out_cnt <= 3'd0;
        r_id_idx  <= 2'd1;
      end else if (w_sck_fall && r_state == S_DATA_OUT) begin
        dq1_o     <= r_tx[7];
        r_out_cnt <= r_out_cnt + 3'd1;
        if (r_out_cnt == 3'd7) begin
          r_tx <= w_load_byte;
          if (r_opcode == OP_READ) r_addr <= r_addr + AW'(1);
          if (r_id_idx != 2'd3) r_id_idx <= r_id_idx + 2'd1;
        end else begin
          r_tx <= {r_tx[6:0], 1'b0};
        end
      end
      if (w_s_rise) dq1_o <= 1'b0;
      if (w_set_wel) wel <= 1'b1;
      else if (w_start_be || w_start_se || w_start_pp) wel <= 1'b0;
      if (w_start_be) begin
        r_er_addr <= '0;
        r_er_last <= LAST_ADDR;
      end else if (w_start_se) begin
        r_er_addr <= w_addr_nx & ~SECT_MASK;
        r_er_last <= w_addr_nx | SECT_MASK;
      end else if (r_bsy == S_ERASE) begin
        r_er_addr <= r_er_addr + AW'(1);
      end
      if (w_start_be || w_start_se || w_start_pp) r_busy_cnt <= '0;
      else if (r_busy_cnt != CW'(BUSY_CYCLES)) r_busy_cnt <= r_busy_cnt + CW'(1);
    end
  end

  // Busy engine state register
  always_ff @(posedge clk) begin
    if (reset) r_bsy <= S_IDLE;
    else       r_bsy <= w_bsy_nx;
  end

  // Busy engine: erase loop, then hold until the minimum busy time has elapsed
  always_comb begin
    w_bsy_nx = r_bsy;
    case (r_bsy)
      S_IDLE: begin
        if (w_start_be || w_start_se) w_bsy_nx = S_ERASE;
        else if (w_start_pp)          w_bsy_nx = S_PROG_WAIT;
      end
      S_ERASE:     if (r_er_addr == r_er_last) w_bsy_nx = S_PROG_WAIT;
      S_PROG_WAIT: if (r_busy_cnt == CW'(BUSY_CYCLES)) w_bsy_nx = S_IDLE;
      default:     w_bsy_nx = S_IDLE;
    endcase
  end

  // Byte RAM: erase fill or flash-style AND programming; contents survive reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (r_bsy == S_ERASE) r_ram[r_er_addr] <= 8'hFF;
      else if (w_pp_we)     r_ram[r_addr]    <= r_ram[r_addr] & w_rx_byte;
    end
  end

endmodule

// File: tb/tb_qspi_flash_responder.sv
// Directed bench for qspi_flash_responder: a mode-0 SPI master drives frames,
// expected MISO bytes are queued before each frame and popped as bytes arrive.
module tb_qspi_flash_responder;

  logic clk = 1'b0;
  logic reset, sck, S, dq0_i;
  logic dq1_o, dq1_oe, wip, wel;

  int         n_assert = 0;
  int         n_fail   = 0;
  int         oe_cycles = 0;
  logic [7:0] exp_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] last_rx;

  always #5 clk = ~clk;

  always @(posedge clk) if (dq1_oe === 1'b1) oe_cycles <= oe_cycles + 1;

  qspi_flash_responder dut (
    .clk(clk), .reset(reset), .sck(sck), .S(S), .dq0_i(dq0_i),
    .dq1_o(dq1_o), .dq1_oe(dq1_oe), .wip(wip), .wel(wel)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_assert++;
    assert (got === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
    end
  endtask

  // One frame of nbits; bytes at index >= nskip are scored against exp_q
  task automatic spi_frame(input int nbits, input int nskip, input string tag);
    logic [7:0] rxb;
    logic [7:0] cur;
    int         bi;
    rxb = 8'h00;
    S = 1'b0;
    #100;
    for (int i = 0; i < nbits; i++) begin
      bi    = i / 8;
      cur   = (bi < tx_q.size()) ? tx_q[bi] : 8'h00;
      dq0_i = cur[7 - (i % 8)];
      #50 sck = 1'b1;
      rxb = {rxb[6:0], dq1_o};
      #50 sck = 1'b0;
      if (i % 8 == 7) begin
        last_rx = rxb;
        if (bi >= nskip && exp_q.size() > 0) check(tag, rxb, exp_q.pop_front());
      end
    end
    #50 S = 1'b1;
    dq0_i = 1'b0;
    #200;
    tx_q.delete();
    exp_q.delete();
  endtask

  task automatic wren();
    tx_q = '{8'h06};
    spi_frame(8, 99, "wren");
  endtask

  task automatic wait_ready(input string tag);
    int polls;
    polls = 0;
    do begin
      tx_q = '{8'h70};
      spi_frame(16, 99, tag);
      polls++;
    end while (last_rx != 8'h80 && polls < 200);
    check(tag, last_rx, 8'h80);
  endtask

  task automatic pp1(input logic [23:0] a, input logic [7:0] d);
    wren();
    tx_q = '{8'h02, a[23:16], a[15:8], a[7:0], d};
    spi_frame(40, 99, "pp");
    wait_ready("pp_ready");
  endtask

  // Caller queues the n expected data bytes first
  task automatic read_chk(input logic [23:0] a, input int n, input string tag);
    tx_q = '{8'h03, a[23:16], a[15:8], a[7:0]};
    spi_frame(32 + 8 * n, 4, tag);
  endtask

  initial begin
    int  oe_before;
    time t0;
    reset = 1'b1; sck = 1'b0; S = 1'b1; dq0_i = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_dq1_o", dq1_o, 0);
    check("rst_dq1_oe", dq1_oe, 0);
    check("rst_wip", wip, 0);
    check("rst_wel", wel, 0);

    // RDID: three ID bytes then zeros
    oe_before = oe_cycles;
    exp_q = '{8'h20, 8'hBA, 8'h18, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    tx_q  = '{8'h9F};
    spi_frame(72, 1, "rdid");
    check("rdid_oe_after", dq1_oe, 0);
    check("rdid_oe_seen", 32'(oe_cycles > oe_before), 1);

    // Short WREN leaves wel clear; full WREN sets it
    tx_q = '{8'h06};
    spi_frame(5, 99, "wren5");
    check("wren5_wel", wel, 0);
    exp_q = '{8'h00};
    tx_q  = '{8'h05};
    spi_frame(16, 1, "rdsr_nowel");
    wren();
    check("wren_wel", wel, 1);
    exp_q = '{8'h02, 8'h02};
    tx_q  = '{8'h05};
    spi_frame(24, 1, "rdsr_wel");

    // Bulk erase, busy polling, then all 0xFF
    t0 = $time;
    tx_q = '{8'hC7};
    spi_frame(8, 99, "be");
    check("be_wip", wip, 1);
    check("be_wel", wel, 0);
    exp_q = '{8'h00};
    tx_q  = '{8'h70};
    spi_frame(16, 1, "rfsr_busy");
    wait_ready("be_ready");
    check("be_min_time", 32'(($time - t0) >= 64'd41600), 1);
    exp_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    read_chk(24'h000000, 8, "read_erased");

    // Page program with in-page wrap
    wren();
    tx_q = '{8'h02, 8'h00, 8'h00, 8'hFE, 8'h11, 8'h22, 8'h33};
    spi_frame(56, 99, "pp3");
    wait_ready("pp3_ready");
    exp_q = '{8'h11, 8'h22};
    read_chk(24'h0000FE, 2, "read_fe");
    exp_q = '{8'h33};
    read_chk(24'h000000, 1, "read_wrap");

    // PP without WREN is ignored
    tx_q = '{8'h02, 8'h00, 8'h00, 8'hFE, 8'h00};
    spi_frame(40, 99, "pp_nowel");
    check("pp_nowel_wip", wip, 0);
    exp_q = '{8'h11};
    read_chk(24'h0000FE, 1, "read_nowel");

    // AND semantics of repeated programming
    pp1(24'h000100, 8'hF0);
    pp1(24'h000100, 8'h3C);
    exp_q = '{8'h30};
    read_chk(24'h000100, 1, "read_and");

    // Sector erase of 0x400-0x7FF only
    pp1(24'h0003FF, 8'h5A);
    pp1(24'h000400, 8'h00);
    pp1(24'h0007FF, 8'h00);
    pp1(24'h000800, 8'hC3);
    wren();
    tx_q = '{8'hD8, 8'h00, 8'h04, 8'h00};
    spi_frame(32, 99, "se");
    check("se_wip", wip, 1);
    wait_ready("se_ready");
    exp_q = '{8'h5A, 8'hFF};
    read_chk(24'h0003FF, 2, "read_se_lo");
    exp_q = '{8'hFF, 8'hC3};
    read_chk(24'h0007FF, 2, "read_se_hi");

    // Reset in the middle of a bulk erase
    wren();
    tx_q = '{8'hC7};
    spi_frame(8, 99, "be2");
    repeat (100) @(negedge clk);
    check("be2_wip", wip, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_wip", wip, 0);
    check("midrst_wel", wel, 0);

    // Unknown opcode never drives dq1, next RDSR is sane
    oe_before = oe_cycles;
    tx_q = '{8'hAB, 8'h00};
    spi_frame(16, 99, "unknown");
    check("unknown_oe", 32'(oe_cycles == oe_before), 1);
    exp_q = '{8'h00};
    tx_q  = '{8'h05};
    spi_frame(16, 1, "rdsr_after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/qspi_flash_responder.md
Name: qspi_flash_responder

Overview:
- Synthesizable single-lane SPI (mode 0) flash target for the bench and FPGA loopback.
- Responds to the command set issued by our flash memory controller: RDID, WREN, RDSR, RFSR, PP, SE, BE, plus READ.
- Oversamples the SPI pins in the system clock domain, backs an internal byte RAM and emulates program/erase busy time.
- Quad mode is out of scope.

Parameters:
- DEPTH, 4096: RAM bytes (power of 2); address = received 24-bit address mod DEPTH.
- SECTOR_BYTES, 1024: SE erase granularity (power of 2, <= DEPTH).
- JEDEC_ID, 24'h20BA18: RDID response bytes, MSB first.
- BUSY_CYCLES, 64: minimum clk cycles of WIP after PP/SE/BE.

Ports:
- clk  in  1  system clock; must be >= 4x sck frequency.
- reset  in  1  synchronous, active-high.
- sck  in  1  SPI clock (async to clk).
- S  in  1  chip select, active low (async).
- dq0_i  in  1  serial data in (MOSI).
- dq1_o  out  1  serial data out (MISO).
- dq1_oe  out  1  output enable for dq1.
- wip  out  1  write/erase in progress.
- wel  out  1  write-enable latch.

Behaviour:
- Sync: 2-flop synchronizers on sck, S, dq0_i; edges are detected on synced values. Frame starts on synced S fall and ends on S rise. RTL sees pins 2-3 clk late.
- Serial timing: MSB first. Sample dq0 on sck rise. Update dq1_o on sck fall.
- Reset: dq1_o=0, dq1_oe=0, wip=0, wel=0, FSM=IDLE, counters 0. RAM contents are not reset.
- FSM states: IDLE, OPCODE, ADDR (3 bytes), DATA_IN, DATA_OUT, IGNORE, ERASE, PROG_WAIT.
  - S fall -> OPCODE with bit count 0.
  - The 8th rise latches the opcode and dispatches.
- Opcode dispatch:
  - 0x9F RDID: DATA_OUT; bytes JEDEC_ID[23:16], [15:8], [7:0], then 0x00 until S rise.
  - 0x05 RDSR: repeat {6'b0, wel, wip} each byte.
  - 0x70 RFSR: repeat {~wip, 7'b0}.
  - 0x06 WREN: sets wel at S rise only if exactly 8 bits received.
  - 0x03 READ: ADDR then DATA_OUT from RAM[addr]; addr increments, wrapping at DEPTH.
  - 0x02 PP: ADDR then DATA_IN. Each completed byte does RAM[addr] <= RAM[addr] & byte (flash AND semantics). addr[7:0] increments and wraps within the 256-byte page; upper bits are held.
  - 0xD8 SE: ADDR; valid only if frame ends after exactly 32 bits.
  - 0xC7 BE: valid only if frame ends after exactly 8 bits.
  - Any other opcode -> IGNORE until S rise.
- Busy rejection: while wip=1, any opcode other than RDSR/RFSR -> IGNORE and has no effect.
- Write-enable gating:
  - PP, SE and BE require wel=1 at opcode latch, else IGNORE.
  - PP writes are suppressed unless enabled.
- Completion at S rise:
  - PP with >=1 full data byte -> wip=1, wel=0, PROG_WAIT.
  - Valid SE/BE -> wip=1, wel=0, ERASE.
  - A short or mis-aligned frame (partial byte) aborts: no state change, partial byte discarded. PP bytes already written stay written.
- ERASE: writes 0xFF one byte per clk over the sector (addr & ~(SECTOR_BYTES-1)) or the whole RAM (BE).
- wip clears when both the erase loop is done and BUSY_CYCLES clk have elapsed since S rise.
- dq1_oe=1 only in DATA_OUT while S low. The first output bit drives on the sck fall after the 8th rise (or after the 32nd for READ). dq1_oe clears within 3 clk of S rise.
- Reset mid-frame or mid-erase: return to reset state immediately; an erase in progress stops with partial 0xFF fill.
- Simultaneous S rise and sck rise in the same sync cycle: the sck edge is processed first, then frame end.

Test Plan:
- RDID frame, 64 sck, after reset -> shifted out 0x20BA1800_00000000; dq1_oe=0 after S rise.
- WREN, then RDSR 16 sck -> 0x02, 0x02. WREN aborted after 5 bits -> RDSR returns 0x00.
- WREN, BE, then poll RFSR -> 0x00 while busy, then 0x80 after >=BUSY_CYCLES and 4096 erase cycles. READ @0x000000, 8 bytes -> all 0xFF.
- WREN, PP @0x0000FE with data 0x11,0x22,0x33, wait ready, then READ @0x0000FE, 2 bytes -> 0x11,0x22.
  - READ @0x000000 -> 0x33 (page wrap).
  - A second PP without WREN of 0x00 @0x0000FE leaves 0x11.
- PP 0xF0 then PP 0x3C to the same byte -> reads 0x30. SE @0x000400 erases 0x400-0x7FF only; 0x3FF is unchanged.
- Assert reset mid-BE -> wip=0, wel=0 next cycle. Unknown opcode 0xAB -> dq1_oe stays 0; the next RDSR is correct.
